// File: rtl/window3x3.sv
// 3x3 sliding-window builder fed by three aligned line-buffer rows.
// Emits each in-line window and, one clock later, its unsigned box sum.
module window3x3 #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LENGTH     = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     data_in_0,
  input  logic [DATA_WIDTH-1:0]     data_in_1,
  input  logic [DATA_WIDTH-1:0]     data_in_2,
  input  logic                      in_valid,
  output logic [9*DATA_WIDTH-1:0]   win_out,
  output logic                      win_valid,
  output logic [DATA_WIDTH+3:0]     win_sum,
  output logic                      sum_valid,
  output logic                      line_done
);

  localparam int unsigned SumWidth = DATA_WIDTH + 4;
  localparam logic [ADDR_WIDTH-1:0] LastCol = ADDR_WIDTH'(LENGTH - 1);

  typedef enum logic [0:0] {StFill, StRun} state_e;

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_col_cnt;
  logic [DATA_WIDTH-1:0]   r_tap [3][3];
  logic [9*DATA_WIDTH-1:0] r_win_out;
  logic                    r_win_valid;
  logic [SumWidth-1:0]     r_win_sum;
  logic                    r_sum_valid;
  logic                    r_line_done;

  logic [DATA_WIDTH-1:0]   w_din [3];
  logic [SumWidth-1:0]     w_sum;
  logic                    w_last;

  assign w_din[0] = data_in_0;
  assign w_din[1] = data_in_1;
  assign w_din[2] = data_in_2;
  assign w_last   = (r_col_cnt == LastCol);

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + SumWidth'(r_win_out[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFill;
      r_col_cnt   <= '0;
      r_win_out   <= '0;
      r_win_valid <= 1'b0;
      r_win_sum   <= '0;
      r_sum_valid <= 1'b0;
      r_line_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_tap[r][c] <= '0;
        end
      end
    end else begin
      r_win_valid <= 1'b0;
      r_line_done <= 1'b0;
      r_sum_valid <= r_win_valid;
      if (r_win_valid) begin
        r_win_sum <= w_sum;
      end
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_tap[r][2] <= r_tap[r][1];
          r_tap[r][1] <= r_tap[r][0];
          r_tap[r][0] <= w_din[r];
        end
        r_col_cnt   <= w_last ? '0 : r_col_cnt + 1'b1;
        r_line_done <= w_last;
        unique case (r_state)
          StFill: begin
            if (r_col_cnt == ADDR_WIDTH'(1)) begin
              r_state <= StRun;
            end
          end
          StRun: begin
            r_win_valid <= 1'b1;
            // Window is the post-shift tap contents: oldest column first.
            for (int r = 0; r < 3; r++) begin
              r_win_out[(r*3+0)*DATA_WIDTH +: DATA_WIDTH] <= r_tap[r][1];
              r_win_out[(r*3+1)*DATA_WIDTH +: DATA_WIDTH] <= r_tap[r][0];
              r_win_out[(r*3+2)*DATA_WIDTH +: DATA_WIDTH] <= w_din[r];
            end
            if (w_last) begin
              r_state <= StFill;
            end
          end
          default: r_state <= StFill;
        endcase
      end
    end
  end

  assign win_out   = r_win_out;
  assign win_valid = r_win_valid;
  assign win_sum   = r_win_sum;
  assign sum_valid = r_sum_valid;
  assign line_done = r_line_done;

endmodule

// File: tb/tb_window3x3.sv
// Bench for window3x3: a 5-pixel/8-bit instance checked every cycle against a column-indexed
// line model, plus a default-size instance checked through window/sum queues.
module tb_window3x3;

  localparam int SL  = 5;
  localparam int SDW = 8;
  localparam int BL  = 100;
  localparam int BDW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [SDW-1:0]   s_d0, s_d1, s_d2;
  logic             s_in_valid;
  logic [9*SDW-1:0] s_win_out;
  logic             s_win_valid, s_sum_valid, s_line_done;
  logic [SDW+3:0]   s_win_sum;

  logic [BDW-1:0]   b_d0, b_d1, b_d2;
  logic             b_in_valid;
  logic [9*BDW-1:0] b_win_out;
  logic             b_win_valid, b_sum_valid, b_line_done;
  logic [BDW+3:0]   b_win_sum;

  window3x3 #(.ADDR_WIDTH(3), .DATA_WIDTH(SDW), .LENGTH(SL)) u_small (
    .clk(clk), .rst_n(rst_n),
    .data_in_0(s_d0), .data_in_1(s_d1), .data_in_2(s_d2), .in_valid(s_in_valid),
    .win_out(s_win_out), .win_valid(s_win_valid), .win_sum(s_win_sum),
    .sum_valid(s_sum_valid), .line_done(s_line_done)
  );

  window3x3 u_big (
    .clk(clk), .rst_n(rst_n),
    .data_in_0(b_d0), .data_in_1(b_d1), .data_in_2(b_d2), .in_valid(b_in_valid),
    .win_out(b_win_out), .win_valid(b_win_valid), .win_sum(b_win_sum),
    .sum_valid(b_sum_valid), .line_done(b_line_done)
  );

  int n_run = 0;
  int n_fail = 0;

  // Small-instance model: pixels stored by (row, column-in-line).
  int               m_col;
  logic [SDW-1:0]   hist [3][SL];
  logic [9*SDW-1:0] e_win;
  logic [SDW+3:0]   e_sum, pend_sum;
  logic             e_wv, e_ld, e_sv;

  task automatic model_reset();
    m_col = 0;
    e_win = '0;
    e_sum = '0;
    pend_sum = '0;
    e_wv = 1'b0;
    e_ld = 1'b0;
    e_sv = 1'b0;
  endtask

  // One clock on the small instance; afterwards e_* hold the expected outputs.
  task automatic cycle_s(input logic v, input logic [SDW-1:0] a0, a1, a2);
    logic [SDW-1:0] px;
    s_in_valid = v;
    s_d0 = v ? a0 : SDW'($urandom);
    s_d1 = v ? a1 : SDW'($urandom);
    s_d2 = v ? a2 : SDW'($urandom);
    @(posedge clk);
    #1;
    e_sv = e_wv;
    if (e_wv) e_sum = pend_sum;
    e_wv = 1'b0;
    e_ld = 1'b0;
    if (v) begin
      hist[0][m_col] = a0;
      hist[1][m_col] = a1;
      hist[2][m_col] = a2;
      if (m_col >= 2) begin
        e_wv = 1'b1;
        pend_sum = '0;
        for (int r = 0; r < 3; r++) begin
          for (int k = 0; k < 3; k++) begin
            px = hist[r][m_col-2+k];
            e_win[(r*3+k)*SDW +: SDW] = px;
            pend_sum = pend_sum + 12'(px);
          end
        end
      end
      e_ld = (m_col == SL - 1);
      m_col = (m_col == SL - 1) ? 0 : m_col + 1;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_in_valid = 1'b0;
    b_in_valid = 1'b0;
    {s_d0, s_d1, s_d2} = '0;
    {b_d0, b_d1, b_d2} = '0;
    #12;
    n_run++;
    if ({s_win_valid, s_sum_valid, s_line_done} !== 3'b000 || s_win_out !== '0 || s_win_sum !== '0) begin
      n_fail++;
      $display("FAIL reset_small: valid/ld=%b win=%h sum=%h required all zero",
               {s_win_valid, s_sum_valid, s_line_done}, s_win_out, s_win_sum);
    end
    n_run++;
    if ({b_win_valid, b_sum_valid, b_line_done} !== 3'b000 || b_win_out !== '0 || b_win_sum !== '0) begin
      n_fail++;
      $display("FAIL reset_big: valid/ld=%b sum=%h required all zero",
               {b_win_valid, b_sum_valid, b_line_done}, b_win_sum);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    int nwin = 0;
    int ld_win = -1;
    logic [SDW+3:0] first_sum = '1;
    logic got_sum = 1'b0;
    for (int c = 0; c < SL + 2; c++) begin
      if (c < SL) cycle_s(1'b1, SDW'(c), SDW'(10 + c), SDW'(20 + c));
      else cycle_s(1'b0, '0, '0, '0);
      if (s_win_valid) nwin++;
      if (s_line_done) ld_win = nwin;
      if (s_sum_valid && !got_sum) begin
        first_sum = s_win_sum;
        got_sum = 1'b1;
      end
      n_run++;
      if ({s_win_valid, s_line_done, s_sum_valid} !== {e_wv, e_ld, e_sv}) begin
        n_fail++;
        $display("FAIL ramp_flags c=%0d got=%b required=%b", c,
                 {s_win_valid, s_line_done, s_sum_valid}, {e_wv, e_ld, e_sv});
      end
      n_run++;
      if (s_win_out !== e_win) begin
        n_fail++;
        $display("FAIL ramp_win c=%0d got=%h required=%h", c, s_win_out, e_win);
      end
      n_run++;
      if (s_win_sum !== e_sum) begin
        n_fail++;
        $display("FAIL ramp_sum c=%0d got=%0d required=%0d", c, s_win_sum, e_sum);
      end
    end
    n_run++;
    if (nwin !== 3) begin
      n_fail++;
      $display("FAIL ramp_count got=%0d required=3", nwin);
    end
    n_run++;
    if (first_sum !== 12'd99) begin
      n_fail++;
      $display("FAIL ramp_first_sum got=%0d required=99", first_sum);
    end
    n_run++;
    if (ld_win !== 3) begin
      n_fail++;
      $display("FAIL ramp_line_done with window %0d required 3", ld_win);
    end
  endtask

  task automatic test_back_to_back();
    int nwin = 0;
    for (int c = 0; c < 2 * SL + 2; c++) begin
      if (c < 2 * SL) cycle_s(1'b1, SDW'($urandom), SDW'($urandom), SDW'($urandom));
      else cycle_s(1'b0, '0, '0, '0);
      if (s_win_valid) nwin++;
      n_run++;
      if ({s_win_valid, s_line_done, s_sum_valid} !== {e_wv, e_ld, e_sv}) begin
        n_fail++;
        $display("FAIL b2b_flags c=%0d got=%b required=%b", c,
                 {s_win_valid, s_line_done, s_sum_valid}, {e_wv, e_ld, e_sv});
      end
      n_run++;
      if (s_win_out !== e_win || s_win_sum !== e_sum) begin
        n_fail++;
        $display("FAIL b2b_data c=%0d win=%h sum=%0d required win=%h sum=%0d", c,
                 s_win_out, s_win_sum, e_win, e_sum);
      end
    end
    n_run++;
    if (nwin !== 6) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d required=6", nwin);
    end
  endtask

  task automatic test_gaps();
    for (int c = 0; c < SL + 2; c++) begin
      int gap = $urandom_range(1, 3);
      for (int g = 0; g <= gap; g++) begin
        if (g == gap && c < SL) cycle_s(1'b1, SDW'($urandom), SDW'($urandom), SDW'($urandom));
        else cycle_s(1'b0, '0, '0, '0);
        n_run++;
        if ({s_win_valid, s_line_done, s_sum_valid} !== {e_wv, e_ld, e_sv}) begin
          n_fail++;
          $display("FAIL gaps_flags c=%0d g=%0d got=%b required=%b", c, g,
                   {s_win_valid, s_line_done, s_sum_valid}, {e_wv, e_ld, e_sv});
        end
        n_run++;
        if (s_win_out !== e_win || s_win_sum !== e_sum) begin
          n_fail++;
          $display("FAIL gaps_data c=%0d win=%h sum=%0d required win=%h sum=%0d", c,
                   s_win_out, s_win_sum, e_win, e_sum);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic [SDW-1:0] v;
    logic [SDW+3:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      v = (pass == 0) ? 8'hFF : 8'h00;
      want = (pass == 0) ? 12'd2295 : 12'd0;
      for (int c = 0; c < SL + 2; c++) begin
        if (c < SL) cycle_s(1'b1, v, v, v);
        else cycle_s(1'b0, '0, '0, '0);
        n_run++;
        if ({s_win_valid, s_line_done, s_sum_valid} !== {e_wv, e_ld, e_sv}) begin
          n_fail++;
          $display("FAIL extreme_flags pass=%0d c=%0d got=%b required=%b", pass, c,
                   {s_win_valid, s_line_done, s_sum_valid}, {e_wv, e_ld, e_sv});
        end
        if (s_sum_valid) begin
          n_run++;
          if (s_win_sum !== want) begin
            n_fail++;
            $display("FAIL extreme_sum pass=%0d got=%0d required=%0d", pass, s_win_sum, want);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    for (int c = 0; c < 3; c++) cycle_s(1'b1, SDW'($urandom), SDW'($urandom), SDW'($urandom));
    n_run++;
    if (s_win_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre win_valid=%b required=1", s_win_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({s_win_valid, s_sum_valid, s_line_done} !== 3'b000 || s_win_out !== '0 || s_win_sum !== '0) begin
      n_fail++;
      $display("FAIL midrst_async valid/ld=%b win=%h sum=%h required all zero",
               {s_win_valid, s_sum_valid, s_line_done}, s_win_out, s_win_sum);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < SL; c++) begin
      cycle_s(1'b1, SDW'($urandom), SDW'($urandom), SDW'($urandom));
      if (s_win_valid && first < 0) first = c + 1;
      n_run++;
      if ({s_win_valid, s_line_done} !== {e_wv, e_ld} || s_win_out !== e_win) begin
        n_fail++;
        $display("FAIL midrst_line c=%0d got=%b win=%h required=%b win=%h", c,
                 {s_win_valid, s_line_done}, s_win_out, {e_wv, e_ld}, e_win);
      end
    end
    n_run++;
    if (first !== 3) begin
      n_fail++;
      $display("FAIL midrst_first_window beat=%0d required=3", first);
    end
    cycle_s(1'b0, '0, '0, '0);
  endtask

  task automatic test_default();
    logic [BDW-1:0]   bh [3][BL];
    logic [9*BDW-1:0] qwin [$];
    logic [BDW+3:0]   qsum [$];
    logic [9*BDW-1:0] w;
    logic [BDW+3:0]   s;
    int col = 0;
    int n_wv = 0;
    int n_sv = 0;
    int n_ld = 0;
    for (int t = 0; t < 3 * BL + 3; t++) begin
      if (t < 3 * BL) begin
        b_in_valid = 1'b1;
        b_d0 = BDW'($urandom);
        b_d1 = BDW'($urandom);
        b_d2 = BDW'($urandom);
        bh[0][col] = b_d0;
        bh[1][col] = b_d1;
        bh[2][col] = b_d2;
        if (col >= 2) begin
          s = '0;
          for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
              w[(r*3+k)*BDW +: BDW] = bh[r][col-2+k];
              s = s + 20'(bh[r][col-2+k]);
            end
          end
          qwin.push_back(w);
          qsum.push_back(s);
        end
        col = (col == BL - 1) ? 0 : col + 1;
      end else begin
        b_in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (b_line_done) n_ld++;
      if (b_win_valid) begin
        n_wv++;
        n_run++;
        if (qwin.size() == 0) begin
          n_fail++;
          $display("FAIL default_win t=%0d unexpected window", t);
        end else begin
          w = qwin.pop_front();
          if (b_win_out !== w) begin
            n_fail++;
            $display("FAIL default_win t=%0d got=%h required=%h", t, b_win_out, w);
          end
        end
      end
      if (b_sum_valid) begin
        n_sv++;
        n_run++;
        if (qsum.size() == 0) begin
          n_fail++;
          $display("FAIL default_sum t=%0d unexpected sum", t);
        end else begin
          s = qsum.pop_front();
          if (b_win_sum !== s) begin
            n_fail++;
            $display("FAIL default_sum t=%0d got=%0d required=%0d", t, b_win_sum, s);
          end
        end
      end
    end
    b_in_valid = 1'b0;
    n_run++;
    if (n_wv !== 294) begin
      n_fail++;
      $display("FAIL default_win_count got=%0d required=294", n_wv);
    end
    n_run++;
    if (n_ld !== 3) begin
      n_fail++;
      $display("FAIL default_line_done_count got=%0d required=3", n_ld);
    end
    n_run++;
    if (n_sv !== 294) begin
      n_fail++;
      $display("FAIL default_sum_count got=%0d required=294 (win count %0d)", n_sv, n_wv);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_gaps();
    test_extremes();
    test_reset_mid();
    test_default();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
